alu_issue_unit: RTL and testbench

Instruction-issue and register-file front end that drives the combinational 16-bit ALU. It accepts one encoded instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's operand and op-select inputs, captures the result and Zero flag, and writes the result back. It sits between the instruction source (test sequencer or future fetch stage) and the ALU.

---
 rtl/alu_issue_unit.sv | 146 ++++++++++++++
 tb/tb_alu_issue_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Issue front end for the 16-bit combinational ALU: accepts one instruction per handshake,
// reads operands from a small register file, captures the ALU result and writes it back.
module alu_issue_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_flag,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        StIdle,
        StOperand,
        StExec,
        StWb
    } state_e;

    state_e state_q, state_d;

    logic [15:0]       instr_q;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] result_q;
    logic              err_q;

    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [3:0] imm4;
    logic       op_legal;
    logic       op_imm;

    assign op       = instr_q[15:12];
    assign rd       = instr_q[11:9];
    assign rs       = instr_q[8:6];
    assign rt       = instr_q[5:3];
    assign imm4     = instr_q[3:0];
    assign op_legal = (op <= 4'd8);
    assign op_imm   = (op == 4'd7) || (op == 4'd8);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    state_d = StOperand;
                end
            end
            StOperand: begin
                // Illegal ops skip EXEC and retire immediately with err.
                state_d = op_legal ? StExec : StWb;
            end
            StExec: begin
                state_d = StWb;
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            result_q  <= '0;
            zero_flag <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        err_q   <= 1'b0;
                    end
                end
                StOperand: begin
                    if (op_legal) begin
                        alu_a  <= (rs == 3'd0) ? '0 : regs[rs];
                        alu_op <= op;
                        if (op_imm) begin
                            alu_b <= {{(DATA_W-4){1'b0}}, imm4};
                        end else begin
                            alu_b <= (rt == 3'd0) ? '0 : regs[rt];
                        end
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                StExec: begin
                    result_q  <= alu_result;
                    zero_flag <= alu_zero;
                end
                StWb: begin
                    // R0 is hard-wired to zero, so writes to it are dropped.
                    if (!err_q && (rd != 3'd0)) begin
                        regs[rd] <= result_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A reset arriving in WB must suppress the retire pulse as well as the write.
    assign instr_ready = (state_q == StIdle) && !rst;
    assign done        = (state_q == StWb) && !rst;
    assign err         = done && err_q;
    assign wb_data     = err_q ? '0 : result_q;
    assign dbg_data    = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed, table-driven bench for alu_issue_unit with a behavioural ALU model attached.
module tb_alu_issue_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        done;
    logic        err;
    logic [15:0] wb_data;
    logic        zero_flag;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks;
    int errors;

    alu_issue_unit #(
        .DATA_W (16),
        .NREG   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .done        (done),
        .err         (err),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 ADDI, 8 SUBI
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = alu_a << alu_b[3:0];
            4'd6:    alu_result = alu_a >> alu_b[3:0];
            4'd7:    alu_result = alu_a + alu_b;
            4'd8:    alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 16'd0);
    end

    typedef struct {
        logic [15:0] ins;
        logic [15:0] exp_wb;
        logic        exp_zero;
        logic        exp_err;
        logic [2:0]  chk_addr;
        logic [15:0] chk_val;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic run_vec(input vec_t v);
        int          waitc;
        logic        legal;
        logic [15:0] rv;
        legal = (v.ins[15:12] <= 4'd8);
        @(negedge clk);
        instr       = v.ins;
        instr_valid = 1'b1;
        waitc = 0;
        while (!instr_ready && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_issue", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'hDEAD;
        @(negedge clk);
        check("no_done_in_operand", {31'd0, done}, 32'd0);
        @(negedge clk);
        if (legal) begin
            check("alu_op", {28'd0, alu_op}, {28'd0, v.ins[15:12]});
            if (v.ins[15:12] == 4'd7 || v.ins[15:12] == 4'd8) begin
                check("alu_b_imm", {16'd0, alu_b}, {28'd0, v.ins[3:0]});
            end
            check("no_done_in_exec", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("done", {31'd0, done}, 32'd1);
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("wb_data", {16'd0, wb_data}, {16'd0, v.exp_wb});
        check("zero_flag", {31'd0, zero_flag}, {31'd0, v.exp_zero});
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after_wb", {31'd0, instr_ready}, 32'd1);
        read_reg(v.chk_addr, rv);
        check("regfile", {16'd0, rv}, {16'd0, v.chk_val});
    endtask

    initial begin
        logic [15:0] rv;
        int          cyc;
        int          n_acc;
        int          n_done;
        int          last_acc;
        int          last_done;
        logic        switch_pending;
        logic        sel;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;

        vecs[0]  = '{16'h7205, 16'h0005, 1'b0, 1'b0, 3'd1, 16'h0005};
        vecs[1]  = '{16'h7405, 16'h0005, 1'b0, 1'b0, 3'd2, 16'h0005};
        vecs[2]  = '{16'h1650, 16'h0000, 1'b1, 1'b0, 3'd3, 16'h0000};
        vecs[3]  = '{16'h5850, 16'h00A0, 1'b0, 1'b0, 3'd4, 16'h00A0};
        vecs[4]  = '{16'h7009, 16'h0009, 1'b0, 1'b0, 3'd0, 16'h0000};
        vecs[5]  = '{16'h9000, 16'h0000, 1'b0, 1'b1, 3'd1, 16'h0005};
        vecs[6]  = '{16'h0B10, 16'h00A5, 1'b0, 1'b0, 3'd5, 16'h00A5};
        vecs[7]  = '{16'h8D45, 16'h00A0, 1'b0, 1'b0, 3'd6, 16'h00A0};
        vecs[8]  = '{16'h8E05, 16'hFFFB, 1'b0, 1'b0, 3'd7, 16'hFFFB};
        vecs[9]  = '{16'h4650, 16'h0000, 1'b1, 1'b0, 3'd3, 16'h0000};
        vecs[10] = '{16'hF850, 16'h0000, 1'b1, 1'b1, 3'd4, 16'h00A0};

        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, instr_ready}, 32'd1);
        check("done_after_reset", {31'd0, done}, 32'd0);
        check("zero_after_reset", {31'd0, zero_flag}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            read_reg(a[2:0], rv);
            check("reg_reset", {16'd0, rv}, 32'd0);
        end

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Reset while 0x7605 sits in EXEC
        @(negedge clk);
        instr       = 16'h7605;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_in_rst", {31'd0, instr_ready}, 32'd0);
        check("abort_no_done_rst", {31'd0, done}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", {31'd0, instr_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
            check("abort_no_err", {31'd0, err}, 32'd0);
        end
        read_reg(3'd3, rv);
        check("abort_r3", {16'd0, rv}, 32'd0);
        read_reg(3'd1, rv);
        check("abort_r1_cleared", {16'd0, rv}, 32'd0);

        // Back-to-back: valid held high, alternating ADDI R1=5 / ADDI R2=3
        sel            = 1'b0;
        switch_pending = 1'b0;
        n_acc          = 0;
        n_done         = 0;
        last_acc       = -100;
        last_done      = -100;
        @(negedge clk);
        instr       = 16'h7205;
        instr_valid = 1'b1;
        for (cyc = 0; cyc < 24; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
            end
            if (switch_pending) begin
                sel            = !sel;
                instr          = sel ? 16'h7403 : 16'h7205;
                switch_pending = 1'b0;
            end
            if (done) begin
                check("b2b_wb_data", {16'd0, wb_data}, (n_done % 2 == 0) ? 32'd5 : 32'd3);
                if (n_done > 0) begin
                    check("b2b_done_spacing", cyc - last_done, 32'd4);
                end
                last_done = cyc;
                n_done++;
            end
            if (instr_ready) begin
                if (n_acc > 0) begin
                    check("b2b_accept_spacing", cyc - last_acc, 32'd4);
                end
                last_acc       = cyc;
                n_acc++;
                switch_pending = 1'b1;
            end
        end
        instr_valid = 1'b0;
        check("b2b_accepts", n_acc, 32'd6);
        check("b2b_dones", n_done, 32'd6);
        @(negedge clk);
        read_reg(3'd1, rv);
        check("b2b_r1", {16'd0, rv}, 32'd5);
        read_reg(3'd2, rv);
        check("b2b_r2", {16'd0, rv}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
